// File: rtl/fpnew_divsqrt_multi_ctrl_pkg.sv
// Shared types and register-placement helpers for the div/sqrt controller and its lane.
package fpnew_divsqrt_multi_ctrl_pkg;

   typedef enum logic [1:0] {
      BEFORE,
      AFTER,
      INSIDE,
      DISTRIBUTED
   } pipe_config_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      HOLD
   } fsm_state_e;

   function automatic int unsigned num_inp_regs(pipe_config_t cfg, int unsigned num_regs);
      case (cfg)
         BEFORE:      return num_regs;
         DISTRIBUTED: return num_regs / 2;
         default:     return 0;
      endcase
   endfunction

   function automatic int unsigned num_out_regs(pipe_config_t cfg, int unsigned num_regs);
      case (cfg)
         AFTER, INSIDE: return num_regs;
         DISTRIBUTED:   return (num_regs + 1) / 2;
         default:       return 0;
      endcase
   endfunction

endpackage

// File: rtl/fpnew_divsqrt_multi_ctrl_if.sv
// Handshake, lane-control and sideband bundle of the div/sqrt controller.
interface fpnew_divsqrt_multi_ctrl_if #(
   parameter int unsigned TagWidth = 4,
   parameter int unsigned AuxWidth = 1,
   parameter int unsigned EnWidth  = 1
);
   logic                in_valid_i;
   logic                in_ready_o;
   logic [TagWidth-1:0] tag_i;
   logic [AuxWidth-1:0] aux_i;
   logic                flush_i;
   logic [EnWidth-1:0]  reg_enable_o;
   logic                fsm_start_o;
   logic                fsm_ready_i;
   logic                unit_done_i;
   logic                flush_o;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [TagWidth-1:0] tag_o;
   logic [AuxWidth-1:0] aux_o;
   logic                busy_o;
   logic                timeout_o;

   modport slave (
      input  in_valid_i, tag_i, aux_i, flush_i, fsm_ready_i, unit_done_i, out_ready_i,
      output in_ready_o, reg_enable_o, fsm_start_o, flush_o, out_valid_o, tag_o, aux_o,
             busy_o, timeout_o
   );

   modport master (
      output in_valid_i, tag_i, aux_i, flush_i, fsm_ready_i, unit_done_i, out_ready_i,
      input  in_ready_o, reg_enable_o, fsm_start_o, flush_o, out_valid_o, tag_o, aux_o,
             busy_o, timeout_o
   );
endinterface

// File: rtl/fpnew_ctrl_pipe_stage.sv
// One valid/payload register slice; ready_i is this slot's acceptance, computed by the parent.
module fpnew_ctrl_pipe_stage #(
   parameter int unsigned DataWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   input  logic                 ready_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 enable_o
);
   logic                 valid_q;
   logic [DataWidth-1:0] data_q;

   assign enable_o = valid_i & ready_i & ~flush_i;
   assign valid_o  = valid_q;
   assign data_o   = data_q;

   // Valid follows the upstream valid whenever the slot can take it; flush empties the slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (ready_i) begin
            valid_q <= valid_i;
         end
         if (enable_o) begin
            data_q <= data_i;
         end
      end
   end
endmodule

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// Handshake/pipeline controller for an iterative div/sqrt lane.
// Optional watchdog: define FPNEW_DIVSQRT_CTRL_TIMEOUT_EN.
module fpnew_divsqrt_multi_ctrl
   import fpnew_divsqrt_multi_ctrl_pkg::*;
#(
   parameter int unsigned  NumPipeRegs   = 0,
   parameter pipe_config_t PipeConfig    = AFTER,
   parameter int unsigned  TagWidth      = 4,
   parameter int unsigned  AuxWidth      = 1,
   parameter int unsigned  TimeoutCycles = 256
) (
   input logic                       clk_i,
   input logic                       rst_i,
   fpnew_divsqrt_multi_ctrl_if.slave bus
);
   localparam int unsigned NumInp       = num_inp_regs(PipeConfig, NumPipeRegs);
   localparam int unsigned NumOut       = num_out_regs(PipeConfig, NumPipeRegs);
   localparam int unsigned PayloadWidth = TagWidth + AuxWidth;
   localparam int unsigned EnWidth      = (NumPipeRegs > 0) ? NumPipeRegs : 1;

   fsm_state_e state_q, state_d;
   logic [PayloadWidth-1:0] op_data_q;

   logic [NumInp:0]                   inp_valid, inp_ready;
   logic [NumInp:0][PayloadWidth-1:0] inp_data;
   logic [NumOut:0]                   out_valid, out_ready;
   logic [NumOut:0][PayloadWidth-1:0] out_data;
   logic [NumInp+NumOut:0]            all_en;

   logic start, done_ok, accept, hold_accept, timeout;

   assign inp_valid[0] = bus.in_valid_i;
   assign inp_data[0]  = {bus.tag_i, bus.aux_i};
   assign all_en[NumInp+NumOut] = 1'b0;

   for (genvar i = 0; i < NumInp; i++) begin : g_inp
      fpnew_ctrl_pipe_stage #(.DataWidth(PayloadWidth)) u_stage (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .flush_i  (bus.flush_i),
         .valid_i  (inp_valid[i]),
         .ready_i  (inp_ready[i]),
         .data_i   (inp_data[i]),
         .valid_o  (inp_valid[i+1]),
         .data_o   (inp_data[i+1]),
         .enable_o (all_en[i])
      );
   end

   // Input ready chain, terminated by the lane start condition.
   always_comb begin
      inp_ready = '0;
      inp_ready[NumInp] = start;
      for (int i = NumInp - 1; i >= 0; i--) begin
         inp_ready[i] = ~inp_valid[i+1] | inp_ready[i+1];
      end
   end

   assign hold_accept = (state_q == HOLD) & out_ready[0];
   assign start = inp_valid[NumInp] & bus.fsm_ready_i & ((state_q == IDLE) | hold_accept) &
                  ~bus.flush_i;
   assign done_ok = bus.unit_done_i & (state_q == BUSY) & ~bus.flush_i;

   // Done is bypassed into output stage 0 the same cycle, mirroring the lane's hold mux.
   assign out_valid[0] = done_ok | ((state_q == HOLD) & ~bus.flush_i);
   assign out_data[0]  = op_data_q;
   assign accept       = out_valid[0] & out_ready[0];

   for (genvar i = 0; i < NumOut; i++) begin : g_out
      fpnew_ctrl_pipe_stage #(.DataWidth(PayloadWidth)) u_stage (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .flush_i  (bus.flush_i),
         .valid_i  (out_valid[i]),
         .ready_i  (out_ready[i]),
         .data_i   (out_data[i]),
         .valid_o  (out_valid[i+1]),
         .data_o   (out_data[i+1]),
         .enable_o (all_en[NumInp+i])
      );
   end

   // Output ready chain from the downstream ready back to stage 0.
   always_comb begin
      out_ready = '0;
      out_ready[NumOut] = bus.out_ready_i;
      for (int i = NumOut - 1; i >= 0; i--) begin
         out_ready[i] = ~out_valid[i+1] | out_ready[i+1];
      end
   end

`ifdef FPNEW_DIVSQRT_CTRL_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   logic [CntWidth-1:0] cnt_q;

   // cnt_q holds the number of completed BUSY cycles, so the limit is hit on the last one.
   assign timeout = (state_q == BUSY) & ~bus.unit_done_i & ~bus.flush_i &
                    (cnt_q == CntWidth'(TimeoutCycles - 1));

   // Watchdog counter: cleared on start, counts while the lane is busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= '0;
      end else if (state_q == BUSY) begin
         cnt_q <= cnt_q + CntWidth'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State and captured op sidebands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            op_data_q <= inp_data[NumInp];
         end
      end
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = BUSY;
         BUSY: begin
            if (timeout) begin
               state_d = IDLE;
            end else if (done_ok) begin
               state_d = accept ? IDLE : HOLD;
            end
         end
         HOLD: if (accept) state_d = start ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush_i) state_d = IDLE;
   end

   assign bus.in_ready_o   = inp_ready[0];
   assign bus.fsm_start_o  = start;
   assign bus.reg_enable_o = EnWidth'(all_en);
   assign bus.flush_o      = bus.flush_i | timeout;
   assign bus.timeout_o    = timeout;
   assign bus.out_valid_o  = out_valid[NumOut];
   assign bus.tag_o        = out_data[NumOut][PayloadWidth-1:AuxWidth];
   assign bus.aux_o        = out_data[NumOut][AuxWidth-1:0];
   assign bus.busy_o       = (|(inp_valid >> 1)) | (|(out_valid >> 1)) | (state_q != IDLE);
endmodule

// File: doc/fpnew_divsqrt_multi_ctrl.md
Name: fpnew_divsqrt_multi_ctrl

Overview:
- Handshake and pipeline controller that drives an externally controlled iterative div/sqrt datapath lane.
- Converts upstream valid/ready and downstream valid/ready handshakes into the lane's control signals: register enables, start pulse and flush.
- Carries tag/aux sidebands alongside each operation and holds the finished result until it is accepted.
- Sits in the opgroup slice, between the issue/arbiter logic and the lane.

Parameters:
- NumPipeRegs, 0, total lane pipeline registers; width of reg_enable_o is max(NumPipeRegs,1).
- PipeConfig, fpnew_pkg::AFTER, register placement. NUM_INP_REGS = NumPipeRegs for BEFORE, NumPipeRegs/2 for DISTRIBUTED, else 0. NUM_OUT_REGS = NumPipeRegs for AFTER/INSIDE, (NumPipeRegs+1)/2 for DISTRIBUTED, else 0.
- TagWidth, 4, width of the tag sideband.
- AuxWidth, 1, width of the aux sideband.
- TimeoutCycles, 256, watchdog limit (used only with the optional feature).

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset.
- in_valid_i in 1: upstream operation valid.
- in_ready_o out 1: upstream ready.
- tag_i in TagWidth: operation tag.
- aux_i in AuxWidth: auxiliary sideband.
- flush_i in 1: synchronous kill of all in-flight work.
- reg_enable_o out max(NumPipeRegs,1): lane register enables; input stages first, then output stages.
- fsm_start_o out 1: start pulse to the lane.
- fsm_ready_i in 1: lane idle / accepting a start.
- unit_done_i in 1: one-cycle pulse when the lane result is valid.
- flush_o out 1: flush forwarded to the lane.
- out_valid_o out 1: result valid.
- out_ready_i in 1: downstream ready.
- tag_o out TagWidth: tag of the result.
- aux_o out AuxWidth: aux of the result.
- busy_o out 1: any work pending.
- timeout_o out 1: watchdog fired (optional feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All stage valids = 0, state = IDLE.
  - All outputs 0, except in_ready_o, which follows its combinational equation.
  - tag_o/aux_o registers = 0.
- Input pipeline: NUM_INP_REGS stages, each holding valid/tag/aux.
  - Stage 0 is the inputs.
  - ready[i] = !valid[i+1] | ready[i+1].
  - reg_enable_o[i] = valid[i] & ready[i]. The enable also loads the stage and sets valid[i+1].
  - in_ready_o = ready[0].
- Start condition (last input stage): start = valid[NUM_INP_REGS] & fsm_ready_i & (state==IDLE | hold_accept).
  - fsm_start_o = start.
  - The ready of the last input stage equals start.
  - Tag/aux are captured into op registers on start.
- FSM states IDLE, BUSY, HOLD:
  - IDLE -> BUSY on start.
  - BUSY -> HOLD on unit_done_i when out stage 0 is not accepted in the same cycle.
  - BUSY -> IDLE on unit_done_i when it is accepted in the same cycle.
  - HOLD -> IDLE on accept.
  - HOLD -> BUSY on accept & start (back-to-back issue).
  - A unit_done_i seen in IDLE or HOLD is ignored.
- Output stage 0:
  - valid0 = (BUSY & unit_done_i) | HOLD. Done is bypassed in the same cycle, matching the lane's hold mux.
  - Carries the captured tag/aux.
  - hold_accept = HOLD & out_ready[0].
- Output pipeline: NUM_OUT_REGS stages with the same ready chain; reg_enable_o[NUM_INP_REGS+i] = valid[i] & ready[i].
  - out_valid_o, tag_o and aux_o come from the last stage.
  - out_ready[NUM_OUT_REGS] = out_ready_i.
- Latency, NumPipeRegs=0: out_valid_o is asserted in the unit_done_i cycle.
- Throughput: one op in flight in the lane. The next start is possible in the accept cycle.
- flush_i:
  - Clears all valids and forces state = IDLE next cycle.
  - flush_o = flush_i, combinational.
  - fsm_start_o and all reg_enable_o are forced to 0 in the flush cycle.
  - unit_done_i coincident with flush is dropped.
- busy_o = |input valids | |output valids | (state != IDLE).
- Reset mid-operation: everything returns to IDLE. The lane is reset by the same reset.

Optional Feature:
- Macro: FPNEW_DIVSQRT_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on start and increments in BUSY.
  - When it reaches TimeoutCycles without unit_done_i: timeout_o pulses for 1 cycle, flush_o is asserted that cycle, and state goes to IDLE with no result produced.
- Without the macro: no counter, and timeout_o is tied to 0.

Decomposition:
- fpnew_pkg: add the fsm_state_e typedef (IDLE/BUSY/HOLD) and functions num_inp_regs(PipeConfig,NumPipeRegs) and num_out_regs(...), shared with the lane.
- One sub-module, fpnew_ctrl_pipe_stage: a valid/ready register slice with a sideband payload and an enable output, instantiated per input and output stage.

Test Plan:
1. NumPipeRegs=0: in_valid with tag=3, fsm_ready=1 -> fsm_start in the same cycle; unit_done 12 cycles later -> out_valid with tag_o=3 in that cycle.
2. out_ready_i=0 for 5 cycles after done -> HOLD, out_valid held with tag stable, in_ready_o=0. out_ready_i=1 together with a new in_valid (tag=5) -> new fsm_start in the same cycle.
3. NumPipeRegs=2, DISTRIBUTED -> reg_enable_o[0] pulses at input accept; start 1 cycle later; reg_enable_o[1] fires on the done cycle; out_valid 1 cycle after done.
4. flush_i while BUSY -> flush_o=1, state IDLE; a later unit_done_i is ignored and no out_valid appears; busy_o=0 the next cycle.
5. fsm_ready_i=0 while the input is valid -> no start, in_ready_o=0; fsm_ready_i rises -> start with the correct tag.
6. TIMEOUT_EN, TimeoutCycles=8: start with no done -> timeout_o pulses exactly 8 cycles after start, flush_o=1 that cycle, then IDLE.
